sd_cmd_sequencer: RTL
=====================

# sd_cmd_sequencer

Bus-side master that drives the SD controller's byte-wide register port to execute one complete SD command per request. It clears the command interrupt status, loads the command and argument registers, polls command-interrupt status until completion or timeout, reads back the response words, and returns status and response to the requester. It sits between a host-side command queue or CPU shim and the register block, and is the only master on that port while a command is in flight.

## Interface
- `CMD_W`, 14: width of the command register, equal to `CMD_REG_SIZE`.
- `ISR_W`, 5: width of command interrupt status, equal to `INT_CMD_SIZE`.
- `POLL_LIMIT`, 65535: maximum number of POLL cycles before a sequencer timeout.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: command request.
- `req_ready` out 1: sequencer idle; a request is accepted when `req_valid && req_ready`.
- `req_cmd` in CMD_W: value for the command register.
- `req_arg` in 32: value for the argument register.
- `req_long` in 1: 1 = read resp0..resp3 (136-bit R2); 0 = read resp0 only.
- `rsp_valid` out 1: result available; held until `rsp_ready`.
- `rsp_ready` in 1: result consumed.
- `rsp_status` out ISR_W: final cmd_isr snapshot. Bit0 = complete, bit1 = error.
- `rsp_timeout` out 1: POLL_LIMIT was exhausted.
- `rsp_data` out 128: {resp3, resp2, resp1, resp0}. Words not read are 0.
- `reg_we` out 1: register port write strobe.
- `reg_addr` out 7: register byte address.
- `reg_wdata` out 8: write byte.
- `reg_rdata` in 8: combinational read data for the current `reg_addr`.

## Operation
- States: IDLE, CLR_ISR, WR_CMD, WR_ARG, POLL, RD_RESP, DONE.
- IDLE: `req_ready`=1. On accept, latch `req_cmd`, `req_arg` and `req_long`, clear `rsp_data`, then go to CLR_ISR.
- CLR_ISR: one cycle writing 0x00 to 0x34 (`cmd_isr`; the write pulses `cmd_int_rst`).
- WR_CMD: two cycles. Write 0x04 with cmd[7:0], then 0x05 with cmd[CMD_W-1:8] zero-extended.
- WR_ARG: four cycles. Write 0x00..0x03 with arg bytes 0..3. Byte 3 is always the last write; it is the effective `cmd_start`.
- POLL: each cycle, drive `reg_addr`=0x34 and `reg_we`=0, sample `reg_rdata[ISR_W-1:0]`, and increment the poll counter.
  - If bit0 or bit1 is set: latch status. Go to RD_RESP if bit1=0, otherwise DONE.
  - If the counter reaches POLL_LIMIT: set `rsp_timeout` and go to DONE. Status latches whatever was last sampled.
  - Completion wins over timeout when both occur in the same cycle.
- RD_RESP: a byte counter `k` runs from 0 to 3 (short) or 0 to 15 (long).
  - Address is 0x08 + k, covering resp0 at 0x08..0x0B through resp3 at 0x14..0x17.
  - Each cycle, `reg_rdata` is stored into `rsp_data[8k+7:8k]`. Then go to DONE.
- DONE: `rsp_valid`=1 with outputs stable. On `rsp_ready`, go to IDLE. A new request is accepted no earlier than the following cycle.
- `reg_we` is 1 only in CLR_ISR, WR_CMD and WR_ARG. `reg_addr` and `reg_wdata` are 0 in IDLE and DONE.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_status`=0, `rsp_timeout`=0, `rsp_data`=0, `reg_we`=0, `reg_addr`=0, `reg_wdata`=0.
- Reset in any state aborts immediately. No further register writes are issued, and no response is produced for the aborted request.

## Timing
- All outputs are registered except `req_ready`, `rsp_valid` and the `reg_*` outputs. These are decoded from state and counters, so they are valid in the same cycle as the state.
- Cycles from accept to first poll: accept cycle (1) + CLR_ISR (1) + WR_CMD (2) + WR_ARG (4). The first POLL cycle is cycle 8 after the accept edge.
- RD_RESP lasts 4 cycles (short) or 16 cycles (long).
- Minimum accept-to-`rsp_valid`, short response, complete on the first poll: 1+1+2+4+1+4 = 13 cycles.
- The poll counter is wide enough to hold POLL_LIMIT and is cleared on entry to POLL.

## Structure
- Shared package `sd_seq_pkg` holds:
  - the state enum;
  - register byte-address constants: ARG 0x00, CMD 0x04, RESP0 0x08, CMD_ISR 0x34;
  - ISR bit indices: CC=0, EI=1.
- Address constants must match those in `sd_defines.h`.
- No sub-module; one FSM plus a 4-bit byte counter and the poll counter.

## Test plan
- Short command: cmd=0x0119, arg=0xDEADBEEF; register model sets isr=0x01 after 5 polls.
  - Writes in order: 0x34←00, 0x04←19, 0x05←01, 0x00←EF, 0x01←BE, 0x02←AD, 0x03←DE.
  - Response: resp0=0x12345678 gives `rsp_data`=0x…0012345678, status=0x01, timeout=0.
- Long response: req_long=1, resp0..3 = 0x11111111…0x44444444. Expect 16 reads at 0x08..0x17 and `rsp_data`=0x44444444_33333333_22222222_11111111.
- Error: isr=0x03 on the first poll gives `rsp_valid` with status=0x03, no RD_RESP reads, and `rsp_data`=0.
- Timeout: POLL_LIMIT=8 and isr stays 0. After exactly 8 poll cycles, expect `rsp_timeout`=1 and status=0. Completion and limit arriving in the same cycle gives timeout=0.
- Backpressure: hold `rsp_ready`=0 for 10 cycles. Outputs stay stable, `req_ready`=0, and a new `req_valid` is ignored until the cycle after the handshake.
- Reset during WR_ARG (after byte 1): no further `reg_we`, all outputs at reset values next cycle, and the next request runs the full sequence cleanly.

Source files
------------

// File: rtl/sd_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sd_seq_pkg
//  Description : Shared definitions for the SD command sequencer: FSM state
//                type, SD controller register byte addresses and command
//                interrupt status bit positions. Addresses match the
//                controller's register map (sd_defines.h).
//  Revision    : 1.0 - initial release
// ============================================================================
package sd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR_ISR = 3'd1,
        ST_WR_CMD  = 3'd2,
        ST_WR_ARG  = 3'd3,
        ST_POLL    = 3'd4,
        ST_RD_RESP = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_t;

    // Register byte addresses on the controller's register port
    localparam logic [6:0] ADDR_ARG     = 7'h00;
    localparam logic [6:0] ADDR_CMD     = 7'h04;
    localparam logic [6:0] ADDR_RESP0   = 7'h08;
    localparam logic [6:0] ADDR_CMD_ISR = 7'h34;

    // Command interrupt status bits
    localparam int ISR_CC = 0;  // command complete
    localparam int ISR_EI = 1;  // error

endpackage : sd_seq_pkg
`default_nettype wire

// File: rtl/sd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sd_cmd_sequencer
//  Description : Register-port master that executes one SD command per
//                request: clears cmd_isr, writes the command and argument
//                registers (argument byte 3 last, which starts the command),
//                polls cmd_isr until complete/error or a poll limit, reads
//                back resp0 (or resp0..resp3 for R2) and returns the result.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                req_*               - command request (valid/ready)
//                rsp_*               - result (valid/ready), status, timeout,
//                                      128-bit response {resp3..resp0}
//                reg_we/addr/wdata   - byte-wide register port, write side
//                reg_rdata           - combinational read data for reg_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_sequencer
    import sd_seq_pkg::*;
#(
    parameter int CMD_W      = 14,
    parameter int ISR_W      = 5,
    parameter int POLL_LIMIT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic [31:0]       req_arg,
    input  logic              req_long,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ISR_W-1:0]  rsp_status,
    output logic              rsp_timeout,
    output logic [127:0]      rsp_data,
    output logic              reg_we,
    output logic [6:0]        reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata
);

    localparam int             PW        = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;
    localparam logic [PW-1:0]  POLL_LAST = PW'(POLL_LIMIT);

    seq_state_t        state;
    seq_state_t        state_next;

    logic [CMD_W-1:0]  cmd_q;
    logic [31:0]       arg_q;
    logic              long_q;
    logic [3:0]        byte_cnt;
    logic [PW-1:0]     poll_cnt;

    logic [15:0]       cmd_ext;
    logic [3:0]        last_byte;
    logic [PW-1:0]     poll_cnt_inc;
    logic              isr_hit;
    logic              poll_exhausted;
    logic              we_int;

    // Command register is split across two byte addresses; upper byte is
    // zero-extended.
    assign cmd_ext        = 16'(cmd_q);
    assign last_byte      = long_q ? 4'd15 : 4'd3;
    assign poll_cnt_inc   = poll_cnt + PW'(1);
    assign isr_hit        = reg_rdata[ISR_CC] | reg_rdata[ISR_EI];
    assign poll_exhausted = (poll_cnt_inc == POLL_LAST);

    // Reset must suppress any write strobe in the very cycle it is raised,
    // otherwise an in-flight argument byte could still reach the controller.
    assign reg_we = we_int & ~rst;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        we_int     = 1'b0;
        reg_addr   = 7'h00;
        reg_wdata  = 8'h00;

        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ST_CLR_ISR;
                end
            end
            ST_CLR_ISR: begin
                we_int     = 1'b1;
                reg_addr   = ADDR_CMD_ISR;
                state_next = ST_WR_CMD;
            end
            ST_WR_CMD: begin
                we_int    = 1'b1;
                reg_addr  = ADDR_CMD + {3'b000, byte_cnt};
                reg_wdata = byte_cnt[0] ? cmd_ext[15:8] : cmd_ext[7:0];
                if (byte_cnt == 4'd1) begin
                    state_next = ST_WR_ARG;
                end
            end
            ST_WR_ARG: begin
                we_int    = 1'b1;
                reg_addr  = ADDR_ARG + {3'b000, byte_cnt};
                reg_wdata = arg_q[{byte_cnt[1:0], 3'b000} +: 8];
                if (byte_cnt == 4'd3) begin
                    state_next = ST_POLL;
                end
            end
            ST_POLL: begin
                reg_addr = ADDR_CMD_ISR;
                // Completion is examined first so it wins over the limit
                if (isr_hit) begin
                    state_next = reg_rdata[ISR_EI] ? ST_DONE : ST_RD_RESP;
                end else if (poll_exhausted) begin
                    state_next = ST_DONE;
                end
            end
            ST_RD_RESP: begin
                reg_addr = ADDR_RESP0 + {3'b000, byte_cnt};
                if (byte_cnt == last_byte) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, byte/poll counters, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= '0;
            arg_q       <= '0;
            long_q      <= 1'b0;
            byte_cnt    <= 4'd0;
            poll_cnt    <= '0;
            rsp_status  <= '0;
            rsp_timeout <= 1'b0;
            rsp_data    <= '0;
        end else begin
            // Byte counter restarts on every state change so each
            // multi-cycle state sees 0,1,2,...
            if (state_next != state) begin
                byte_cnt <= 4'd0;
            end else if (state == ST_WR_CMD || state == ST_WR_ARG || state == ST_RD_RESP) begin
                byte_cnt <= byte_cnt + 4'd1;
            end

            if (state == ST_POLL) begin
                poll_cnt <= poll_cnt_inc;
            end else begin
                poll_cnt <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cmd_q       <= req_cmd;
                        arg_q       <= req_arg;
                        long_q      <= req_long;
                        rsp_data    <= '0;
                        rsp_status  <= '0;
                        rsp_timeout <= 1'b0;
                    end
                end
                ST_POLL: begin
                    // Keep the latest sample so a timeout reports it
                    rsp_status <= reg_rdata[ISR_W-1:0];
                    if (!isr_hit && poll_exhausted) begin
                        rsp_timeout <= 1'b1;
                    end
                end
                ST_RD_RESP: begin
                    rsp_data[{byte_cnt, 3'b000} +: 8] <= reg_rdata;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : sd_cmd_sequencer
`default_nettype wire
